// File: rtl/sys_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_pkg
// Description : Shared widths and TX state encoding for the sys_ctrl TX path.
// Revision    : 1.0 - initial release
// ============================================================================
package sys_ctrl_pkg;

  localparam int unsigned c_DATA_W = 8;
  localparam int unsigned c_ALU_W  = 2 * c_DATA_W;

  typedef enum logic [1:0] {
    IDLE        = 2'd0,
    SEND_RD     = 2'd1,
    SEND_ALU_LO = 2'd2,
    SEND_ALU_HI = 2'd3
  } tx_state_e;

  // Register-file reads always win over ALU results when both are waiting.
  function automatic tx_state_e arbitrate(input logic rd_pending, input logic alu_pending);
    if (rd_pending) begin
      return SEND_RD;
    end else if (alu_pending) begin
      return SEND_ALU_LO;
    end
    return IDLE;
  endfunction

endpackage
`default_nettype wire

// File: rtl/sys_ctrl_hold_reg.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_hold_reg
// Description : One-entry holding buffer with capture, free and drop detect.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_hold_reg
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = c_DATA_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             strobe_i,
  input  logic             free_i,
  input  logic [WIDTH-1:0] data_i,
  output logic             valid_o,
  output logic             valid_d_o,
  output logic [WIDTH-1:0] data_o,
  output logic             drop_o
);

  logic             valid_q, valid_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             accept;

  // An entry being freed this cycle may be refilled in the same cycle.
  assign accept = strobe_i & (~valid_q | free_i);
  assign drop_o = strobe_i & valid_q & ~free_i;

  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (free_i) begin
      valid_d = 1'b0;
    end
    if (accept) begin
      valid_d = 1'b1;
      data_d  = data_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      data_q  <= '0;
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign valid_o   = valid_q;
  assign valid_d_o = valid_d;
  assign data_o    = data_q;

endmodule
`default_nettype wire

// File: rtl/sys_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module      : sys_ctrl_tx
// Description : Serialises register-file reads and ALU results into TX FIFO bytes.
// Revision    : 1.0 - initial release
// ============================================================================
module sys_ctrl_tx
  import sys_ctrl_pkg::*;
#(
  parameter int unsigned DATA_W = c_DATA_W,
  parameter int unsigned ALU_W  = c_ALU_W
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic [DATA_W-1:0] RD_DATA,
  input  logic              RD_DATA_VLD,
  input  logic [ALU_W-1:0]  ALU_OUT,
  input  logic              ALU_OUT_VLD,
  input  logic              FIFO_FULL,
  output logic [DATA_W-1:0] FIFO_WR_DATA,
  output logic              FIFO_WR_INC,
  output logic              BUSY,
  output logic              DROP
);

  tx_state_e         state_q, state_d;
  logic [DATA_W-1:0] wr_data_q, wr_data_d;
  logic              wr_inc_q, wr_inc_d;
  logic              drop_q, drop_d;

  logic              rd_vld_q, rd_vld_d, rd_free, rd_drop;
  logic [DATA_W-1:0] rd_buf;
  logic              alu_vld_q, alu_vld_d, alu_free, alu_drop;
  logic [ALU_W-1:0]  alu_buf;

  assign rd_free  = (state_q == SEND_RD)     & ~FIFO_FULL;
  assign alu_free = (state_q == SEND_ALU_HI) & ~FIFO_FULL;

  sys_ctrl_hold_reg #(.WIDTH(DATA_W)) u_rd_hold (
    .clk       (CLK),
    .rst       (RST),
    .strobe_i  (RD_DATA_VLD),
    .free_i    (rd_free),
    .data_i    (RD_DATA),
    .valid_o   (rd_vld_q),
    .valid_d_o (rd_vld_d),
    .data_o    (rd_buf),
    .drop_o    (rd_drop)
  );

  sys_ctrl_hold_reg #(.WIDTH(ALU_W)) u_alu_hold (
    .clk       (CLK),
    .rst       (RST),
    .strobe_i  (ALU_OUT_VLD),
    .free_i    (alu_free),
    .data_i    (ALU_OUT),
    .valid_o   (alu_vld_q),
    .valid_d_o (alu_vld_d),
    .data_o    (alu_buf),
    .drop_o    (alu_drop)
  );

  // Arbitration looks at next-cycle occupancy so a fresh strobe or a
  // back-to-back refill is dispatched without an idle bubble.
  always_comb begin
    state_d   = state_q;
    wr_inc_d  = 1'b0;
    wr_data_d = wr_data_q;
    drop_d    = rd_drop | alu_drop;
    case (state_q)
      IDLE: begin
        state_d = arbitrate(rd_vld_d, alu_vld_d);
      end
      SEND_RD: begin
        if (!FIFO_FULL) begin
          wr_inc_d  = 1'b1;
          wr_data_d = rd_buf;
          state_d   = arbitrate(rd_vld_d, alu_vld_d);
        end
      end
      SEND_ALU_LO: begin
        if (!FIFO_FULL) begin
          wr_inc_d  = 1'b1;
          wr_data_d = alu_buf[DATA_W-1:0];
          state_d   = SEND_ALU_HI;
        end
      end
      SEND_ALU_HI: begin
        if (!FIFO_FULL) begin
          wr_inc_d  = 1'b1;
          wr_data_d = alu_buf[ALU_W-1:DATA_W];
          state_d   = arbitrate(rd_vld_d, alu_vld_d);
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q   <= IDLE;
      wr_data_q <= '0;
      wr_inc_q  <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      wr_data_q <= wr_data_d;
      wr_inc_q  <= wr_inc_d;
      drop_q    <= drop_d;
    end
  end

  assign FIFO_WR_DATA = wr_data_q;
  assign FIFO_WR_INC  = wr_inc_q;
  assign DROP         = drop_q;
  assign BUSY         = rd_vld_q | alu_vld_q | (state_q != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_sys_ctrl_tx.sv
`default_nettype none
// ============================================================================
// Module      : tb_sys_ctrl_tx
// Description : Self-checking bench: directed vector table, corner sequences,
//               and randomised traffic against a byte-queue reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_sys_ctrl_tx;

  logic        CLK = 1'b0;
  logic        RST;
  logic [7:0]  RD_DATA;
  logic        RD_DATA_VLD;
  logic [15:0] ALU_OUT;
  logic        ALU_OUT_VLD;
  logic        FIFO_FULL;
  logic [7:0]  FIFO_WR_DATA;
  logic        FIFO_WR_INC;
  logic        BUSY;
  logic        DROP;

  int n_checks = 0;
  int n_errors = 0;

  always #5 CLK = ~CLK;

  sys_ctrl_tx #(.DATA_W(8), .ALU_W(16)) dut (
    .CLK          (CLK),
    .RST          (RST),
    .RD_DATA      (RD_DATA),
    .RD_DATA_VLD  (RD_DATA_VLD),
    .ALU_OUT      (ALU_OUT),
    .ALU_OUT_VLD  (ALU_OUT_VLD),
    .FIFO_FULL    (FIFO_FULL),
    .FIFO_WR_DATA (FIFO_WR_DATA),
    .FIFO_WR_INC  (FIFO_WR_INC),
    .BUSY         (BUSY),
    .DROP         (DROP)
  );

  typedef struct {
    bit          rst;
    bit          rdv;
    logic [7:0]  rdd;
    bit          aluv;
    logic [15:0] alud;
    bit          full;
    bit          e_inc;
    logic [7:0]  e_data;
    bit          e_drop;
    bit          e_busy;
  } vec_t;

  function automatic vec_t mk(bit rst, bit rdv, logic [7:0] rdd, bit aluv, logic [15:0] alud,
                              bit full, bit e_inc, logic [7:0] e_data, bit e_drop, bit e_busy);
    vec_t v;
    v.rst = rst; v.rdv = rdv; v.rdd = rdd; v.aluv = aluv; v.alud = alud; v.full = full;
    v.e_inc = e_inc; v.e_data = e_data; v.e_drop = e_drop; v.e_busy = e_busy;
    return v;
  endfunction

  task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic drive(input bit rst, input bit rdv, input logic [7:0] rdd,
                       input bit aluv, input logic [15:0] alud, input bit full);
    RST = rst; RD_DATA_VLD = rdv; RD_DATA = rdd;
    ALU_OUT_VLD = aluv; ALU_OUT = alud; FIFO_FULL = full;
  endtask

  // One clock: inputs applied on the falling edge, outputs checked 1 ns after the rising edge.
  task automatic cyc(input vec_t v, input string tag);
    @(negedge CLK);
    drive(v.rst, v.rdv, v.rdd, v.aluv, v.alud, v.full);
    @(posedge CLK);
    #1;
    chk({tag, ".inc"},  {15'd0, FIFO_WR_INC}, {15'd0, v.e_inc});
    chk({tag, ".data"}, {8'd0, FIFO_WR_DATA}, {8'd0, v.e_data});
    chk({tag, ".drop"}, {15'd0, DROP},        {15'd0, v.e_drop});
    chk({tag, ".busy"}, {15'd0, BUSY},        {15'd0, v.e_busy});
  endtask

  // Reference model: two slots plus a queue of bytes for the transfer in progress.
  bit          m_rd_v, m_alu_v, job_alu;
  logic [7:0]  m_rd_d;
  logic [15:0] m_alu_d;
  logic [7:0]  job_q[$];
  bit          e_inc, e_drop;
  logic [7:0]  e_data;

  task automatic model_step(input bit rst, input bit rdv, input logic [7:0] rdd,
                            input bit aluv, input logic [15:0] alud, input bit full);
    if (rst) begin
      m_rd_v = 0; m_alu_v = 0; job_q.delete();
      e_inc = 0; e_data = 8'h00; e_drop = 0;
    end else begin
      e_inc = 0; e_drop = 0;
      if (job_q.size() != 0 && !full) begin
        e_data = job_q.pop_front();
        e_inc  = 1;
        if (job_q.size() == 0) begin
          if (job_alu) m_alu_v = 0;
          else         m_rd_v  = 0;
        end
      end
      if (rdv) begin
        if (m_rd_v) e_drop = 1;
        else begin m_rd_v = 1; m_rd_d = rdd; end
      end
      if (aluv) begin
        if (m_alu_v) e_drop = 1;
        else begin m_alu_v = 1; m_alu_d = alud; end
      end
      if (job_q.size() == 0) begin
        if (m_rd_v) begin
          job_q.push_back(m_rd_d); job_alu = 0;
        end else if (m_alu_v) begin
          job_q.push_back(m_alu_d[7:0]); job_q.push_back(m_alu_d[15:8]); job_alu = 1;
        end
      end
    end
  endtask

  vec_t tbl[$];

  initial begin
    drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);

    // Columns: rst rdv rdd aluv alud full | inc data drop busy
    tbl.push_back(mk(1, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0));
    tbl.push_back(mk(0, 1, 8'h5A, 0, 16'h0000, 0,  0, 8'h00, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h5A, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 1, 16'h1234, 0,  0, 8'h5A, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h34, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h12, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h12, 0, 0));
    tbl.push_back(mk(0, 1, 8'hA1, 1, 16'hBEEF, 0,  0, 8'h12, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'hA1, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'hEF, 0, 1));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'hBE, 0, 0));
    tbl.push_back(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'hBE, 0, 0));
    for (int i = 0; i < tbl.size(); i++) begin
      cyc(tbl[i], $sformatf("vec%0d", i));
    end

    // ALU result held off by a full FIFO for five cycles.
    cyc(mk(0, 0, 8'h00, 1, 16'h00FF, 1,  0, 8'hBE, 0, 1), "full.strb");
    for (int i = 0; i < 4; i++) begin
      cyc(mk(0, 0, 8'h00, 0, 16'h0000, 1,  0, 8'hBE, 0, 1), $sformatf("full.hold%0d", i));
    end
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'hFF, 0, 1), "full.lo");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h00, 0, 0), "full.hi");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "full.end");

    // Second RD strobe while the first is stuck behind a full FIFO is dropped.
    cyc(mk(0, 1, 8'h11, 0, 16'h0000, 1,  0, 8'h00, 0, 1), "drop.first");
    cyc(mk(0, 1, 8'h22, 0, 16'h0000, 1,  0, 8'h00, 1, 1), "drop.second");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 1,  0, 8'h00, 0, 1), "drop.wait");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h11, 0, 0), "drop.send");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h11, 0, 0), "drop.end");

    // Strobe in the cycle the buffer is freed is captured: back-to-back bytes.
    cyc(mk(0, 1, 8'h01, 0, 16'h0000, 0,  0, 8'h11, 0, 1), "refill.a");
    cyc(mk(0, 1, 8'h02, 0, 16'h0000, 0,  1, 8'h01, 0, 1), "refill.b");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h02, 0, 0), "refill.c");

    // Reset after the low byte abandons the ALU transfer.
    cyc(mk(0, 0, 8'h00, 1, 16'h1234, 0,  0, 8'h02, 0, 1), "rst.strb");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  1, 8'h34, 0, 1), "rst.lo");
    cyc(mk(1, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "rst.apply");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "rst.after0");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "rst.after1");

    // Strobes during reset are ignored.
    cyc(mk(1, 1, 8'h77, 1, 16'h5566, 0,  0, 8'h00, 0, 0), "rststrb.apply");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "rststrb.after0");
    cyc(mk(0, 0, 8'h00, 0, 16'h0000, 0,  0, 8'h00, 0, 0), "rststrb.after1");

    // Randomised traffic against the reference model.
    model_step(1, 0, 8'h00, 0, 16'h0000, 0);
    @(negedge CLK);
    drive(1'b1, 1'b0, 8'h00, 1'b0, 16'h0000, 1'b0);
    @(posedge CLK);
    #1;
    for (int i = 0; i < 3000; i++) begin
      bit          r_rst, r_rdv, r_aluv, r_full;
      logic [7:0]  r_rdd;
      logic [15:0] r_alud;
      r_rst  = ($urandom_range(199) == 0);
      r_rdv  = ($urandom_range(99) < 30);
      r_aluv = ($urandom_range(99) < 25);
      r_full = ($urandom_range(99) < 30);
      r_rdd  = 8'($urandom_range(255));
      r_alud = 16'($urandom_range(65535));
      @(negedge CLK);
      drive(r_rst, r_rdv, r_rdd, r_aluv, r_alud, r_full);
      model_step(r_rst, r_rdv, r_rdd, r_aluv, r_alud, r_full);
      @(posedge CLK);
      #1;
      chk($sformatf("rnd%0d.inc", i),  {15'd0, FIFO_WR_INC}, {15'd0, e_inc});
      chk($sformatf("rnd%0d.data", i), {8'd0, FIFO_WR_DATA}, {8'd0, e_data});
      chk($sformatf("rnd%0d.drop", i), {15'd0, DROP},        {15'd0, e_drop});
      chk($sformatf("rnd%0d.busy", i), {15'd0, BUSY},
          {15'd0, (m_rd_v | m_alu_v | (job_q.size() != 0))});
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
`default_nettype wire
